// File: rtl/uart_rx_pkg.sv
// Shared constants, FIFO operation encoding and status-word packing for the UART receive buffer.
package uart_rx_pkg;

  localparam int DATA_W     = 8;
  localparam int ST_AVAIL   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_OVR     = 10;
  localparam int ST_FERR    = 11;
  localparam int ST_CNT_LSB = 12;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic logic [15:0] pack_status(
    input logic [DATA_W-1:0] head,
    input logic              avail,
    input logic              full,
    input logic              ovr,
    input logic              ferr,
    input logic [3:0]        cnt
  );
    logic [15:0] s;
    s                    = '0;
    s[DATA_W-1:0]        = head;
    s[ST_AVAIL]          = avail;
    s[ST_FULL]           = full;
    s[ST_OVR]            = ovr;
    s[ST_FERR]           = ferr;
    s[ST_CNT_LSB +: 4]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_edge_det.sv
// Two-flop synchronizer plus registered rising-edge pulse for an asynchronous flag.
// The history flop resets to 1 so a level already high at reset release is not seen as an edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise
);

  logic       meta;
  logic       sync;
  logic       hist;
  logic [1:0] warm;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b1;
      warm <= 2'b00;
      rise <= 1'b0;
    end else begin
      meta <= sig;
      sync <= meta;
      warm <= {warm[0], 1'b1};
      // History stays high until the zeroed chain has refilled, so a held level never looks new.
      hist <= warm[1] ? sync : 1'b1;
      rise <= sync & ~hist;
    end
  end

  assign level = sync;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO presenting head byte, status bits and occupancy as one 16-bit input word.
// Define UART_RX_FIFO_OVERWRITE_EN to make a push while full replace the oldest entry.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  input  logic              pop,
  input  logic              clr_flags,
  output logic [15:0]       status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              valid_level;
  logic              valid_rise;
  logic              err_level;
  logic              err_rise;
  logic              pop_hist;
  logic              pop_rise;
  logic              push_req;
  logic              do_pop;
  logic              empty;
  logic              full;
  fifo_op_e          op;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overrun;
  logic              frame_err;

  logic              wr_en;
  logic              wr_adv;
  logic              rd_adv;
  logic              ovr_set;
  logic [CNT_W-1:0]  count_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head;

  sync_edge_det u_valid_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (rx_valid),
    .level (valid_level),
    .rise  (valid_rise)
  );

  sync_edge_det u_err_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (rx_error),
    .level (err_level),
    .rise  (err_rise)
  );

  // A byte-done flag that collapsed before its edge was registered is not a byte.
  assign push_req = valid_rise & valid_level & ~err_level;
  assign pop_rise = pop & ~pop_hist;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop_rise & ~empty;
  assign op       = fifo_op_e'({push_req, do_pop});

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    wr_en      = 1'b0;
    wr_adv     = 1'b0;
    rd_adv     = 1'b0;
    ovr_set    = 1'b0;
    count_next = count;
    unique case (op)
      OP_BOTH: begin
        wr_en  = 1'b1;
        wr_adv = 1'b1;
        rd_adv = 1'b1;
      end
      OP_PUSH: begin
        if (!full) begin
          wr_en      = 1'b1;
          wr_adv     = 1'b1;
          count_next = count + CNT_W'(1);
        end else begin
          ovr_set = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
          wr_en  = 1'b1;
          wr_adv = 1'b1;
          rd_adv = 1'b1;
`endif
        end
      end
      OP_POP: begin
        rd_adv     = 1'b1;
        count_next = count - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      pop_hist  <= 1'b1;
    end else begin
      pop_hist  <= pop;
      count     <= count_next;
      if (wr_adv) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
      overrun   <= ovr_set  | (overrun   & ~clr_flags);
      frame_err <= err_rise | (frame_err & ~clr_flags);
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count, and a memory reset would cost a port per entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  assign head   = empty ? '0 : mem[rd_ptr];
  assign status = pack_status(head, ~empty, full, overrun, frame_err, 4'(count));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo against a queue-based behavioural model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic        pop;
  logic        clr_flags;
  logic [15:0] status;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .pop       (pop),
    .clr_flags (clr_flags),
    .status    (status)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  fq [$];
  bit          ovr_m;
  bit          ferr_m;
  logic [15:0] sb_q [$];
  logic [15:0] model_last;
  logic [15:0] last_status;
  logic [15:0] mon_exp;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    int n;
    n       = fq.size();
    s       = 16'h0000;
    s[15:12] = 4'(n);
    s[11]   = ferr_m;
    s[10]   = ovr_m;
    s[9]    = (n == DEPTH);
    s[8]    = (n != 0);
    s[7:0]  = (n != 0) ? fq[0] : 8'h00;
    return s;
  endfunction

  task automatic expect_now();
    logic [15:0] e;
    e = exp_status();
    if (e !== model_last) begin
      sb_q.push_back(e);
      model_last = e;
    end
  endtask

  task automatic m_push(input logic [7:0] b, input bit err);
    if (err) ferr_m = 1'b1;
    else if (fq.size() == DEPTH) begin
      ovr_m = 1'b1;
`ifdef UART_RX_FIFO_OVERWRITE_EN
      void'(fq.pop_front());
      fq.push_back(b);
`endif
    end else fq.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit err);
    m_push(b, err);
    expect_now();
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_error = err;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0; rx_error = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic err_only();
    ferr_m = 1'b1;
    expect_now();
    @(posedge clk); #1 rx_error = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_error = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_pop();
    if (fq.size() != 0) void'(fq.pop_front());
    expect_now();
    @(posedge clk); #1 pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_clr();
    ovr_m = 1'b0; ferr_m = 1'b0;
    expect_now();
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(posedge clk);
  endtask

  task automatic push_and_pop(input logic [7:0] b);
    if (fq.size() != 0) void'(fq.pop_front());
    fq.push_back(b);
    expect_now();
    @(posedge clk); #1 rx_data = b; rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0; rx_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en && status !== last_status) begin
      if (sb_q.size() == 0) check("unexpected_change", status, last_status);
      else begin
        mon_exp = sb_q.pop_front();
        check("scoreboard", status, mon_exp);
      end
      last_status = status;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
    pop = 1'b0; clr_flags = 1'b0;
    ovr_m = 1'b0; ferr_m = 1'b0; model_last = 16'h0000;
    repeat (3) @(posedge clk);
    #1 check("reset", status, 16'h0000);
    rst = 1'b0;
    last_status = status;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);

    do_pop();
    check("pop_empty", status, 16'h0000);

    m_push(8'h41, 1'b0);
    expect_now();
    @(posedge clk); #1 rx_data = 8'h41; rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_before", status, 16'h0000);
    @(posedge clk);
    #1 check("latency_at", status, 16'h1141);
    repeat (2) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (4) @(posedge clk);

    do_pop();
    check("pop_one", status, 16'h0000);

    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("full8", status, 16'h8301);
    send_byte(8'h09, 1'b0);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    check("overrun9", status, 16'h8702);
`else
    check("overrun9", status, 16'h8701);
`endif
    do_clr();
    push_and_pop(8'hA0);
`ifdef UART_RX_FIFO_OVERWRITE_EN
    check("both_full", status, 16'h8303);
`else
    check("both_full", status, 16'h8302);
`endif
    while (fq.size() != 0) do_pop();
    check("drained", status, 16'h0000);

    send_byte(8'h55, 1'b1);
    check("ferr_discard", status, 16'h0800);
    do_clr();
    check("ferr_clr", status, 16'h0000);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
        4, 5, 6:    do_pop();
        7:          push_and_pop(8'($urandom));
        8:          do_clr();
        default:    err_only();
      endcase
    end
    check("random_end", status, exp_status());

    do_clr();
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0);
    fq.delete();
    ovr_m = 1'b0; ferr_m = 1'b0;
    expect_now();
    @(posedge clk); #3 rst = 1'b1;
    #1 check("reset_mid", status, 16'h0000);
    rx_data = 8'hEE; rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("valid_through_reset", status, 16'h0000);
    rx_valid = 1'b0;
    repeat (5) @(posedge clk);

    check("sb_drained", 16'(sb_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
